// File: rtl/hello_pkg.sv
// Shared types and default sizes for the hello pulse-train sequencer.
package hello_pkg;

    localparam int HELLO_CNT_W = 16;
    localparam int HELLO_NUM_W = 8;
    localparam int HELLO_LAT   = 1;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        DRAIN,
        DONE
    } hello_seq_state_t;

endpackage

// File: rtl/hello_seq_dly.sv
// LAT-deep shift register that mirrors the hello datapath latency.
// Only instantiated when HELLO_SEQ_CHECK_EN is defined.
module hello_seq_dly
    import hello_pkg::*;
#(
    parameter int LAT = HELLO_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [LAT-1:0] r_sr;

    // Shift the drive value one stage per cycle; stage LAT-1 is LAT cycles old.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < LAT; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/hello_seq.sv
// Pulse-train sequencer driving the hello flop d input.
// Emits num_pulses high/low pairs of half_period cycles each, drains the
// datapath latency, then pulses done. Defining HELLO_SEQ_CHECK_EN adds a
// q_in-vs-delayed-d_out comparator driving the sticky err flag.
module hello_seq
    import hello_pkg::*;
#(
    parameter int CNT_W = HELLO_CNT_W,
    parameter int NUM_W = HELLO_NUM_W,
    parameter int LAT   = HELLO_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] half_period,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             busy,
    output logic             done,
    output logic             d_out,
    input  logic             q_in,
    output logic [NUM_W-1:0] pulse_cnt,
    output logic             err
);

    // Drain counter is 4 bits since LAT is limited to 1..15.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    hello_seq_state_t r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_d;
    logic [NUM_W-1:0] r_pulse_cnt;
    logic [NUM_W-1:0] r_num;
    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_phase;
    logic [3:0]       r_drain;

    logic [CNT_W-1:0] w_hp_eff;
    logic [NUM_W-1:0] w_pc_next;

    // A zero half-period behaves as one cycle per phase.
    assign w_hp_eff  = (half_period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : half_period;
    assign w_pc_next = r_pulse_cnt + 1'b1;

    // Sequencer FSM; phase counter runs hp-1 down to 0 so hp=2^CNT_W-1 fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_d         <= 1'b0;
            r_pulse_cnt <= '0;
            r_num       <= '0;
            r_hp        <= '0;
            r_phase     <= '0;
            r_drain     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_hp        <= w_hp_eff;
                        r_num       <= num_pulses;
                        r_pulse_cnt <= '0;
                        r_busy      <= 1'b1;
                        if (num_pulses == '0) begin
                            r_state <= DRAIN;
                            r_drain <= LAT_M1;
                            r_d     <= 1'b0;
                        end else begin
                            r_state <= HIGH;
                            r_phase <= w_hp_eff - 1'b1;
                            r_d     <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort) begin
                        r_state <= DRAIN;
                        r_drain <= LAT_M1;
                        r_d     <= 1'b0;
                    end else if (r_phase == '0) begin
                        r_state <= LOW;
                        r_phase <= r_hp - 1'b1;
                        r_d     <= 1'b0;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                LOW: begin
                    // Abort wins over a phase end: the partial pulse is not counted.
                    if (abort) begin
                        r_state <= DRAIN;
                        r_drain <= LAT_M1;
                        r_d     <= 1'b0;
                    end else if (r_phase == '0) begin
                        r_pulse_cnt <= w_pc_next;
                        if (w_pc_next == r_num) begin
                            r_state <= DRAIN;
                            r_drain <= LAT_M1;
                        end else begin
                            r_state <= HIGH;
                            r_phase <= r_hp - 1'b1;
                            r_d     <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_d     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign d_out     = r_d;
    assign pulse_cnt = r_pulse_cnt;

`ifdef HELLO_SEQ_CHECK_EN
    // Cycle k after start acceptance is checked once k reaches LAT+1.
    localparam logic [4:0] CHK_FIRST = 5'(LAT + 1);

    logic [4:0] r_elapsed;
    logic       r_err;
    logic       w_d_dly;
    logic       w_in_window;

    hello_seq_dly #(.LAT(LAT)) u_dly (
        .clk (clk),
        .rst (rst),
        .i_d (r_d),
        .o_q (w_d_dly)
    );

    assign w_in_window = ((r_state == HIGH) || (r_state == LOW) || (r_state == DRAIN)) &&
                         (r_elapsed == CHK_FIRST);

    // Track cycles since start (saturating) and latch any q_in mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_elapsed <= '0;
            r_err     <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_elapsed <= 5'd1;
            r_err     <= 1'b0;
        end else begin
            if (r_busy && (r_elapsed != CHK_FIRST)) begin
                r_elapsed <= r_elapsed + 5'd1;
            end
            if (w_in_window && (q_in != w_d_dly)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = q_in;
    assign err        = 1'b0;
`endif

endmodule

// File: doc/hello_seq.md
Name: hello_seq

Overview:
- Programmable pulse-train sequencer that drives the `d` input of the `hello` flop datapath and monitors its `q` output.
- Replaces hand-written testbench toggling of `d` with a start/done-controlled engine.
- Emits N high/low pulses of a configurable half-period, then waits for the datapath latency to drain.
- Sits between a host/bench controller and one `hello` instance; same `clk`, same `rst`.

Parameters:
- CNT_W, 16, width of the half-period counter and the `half_period` input.
- NUM_W, 8, width of the pulse-count field and counters.
- LAT, 1, cycles from `d_out` to `q_in` through the datapath; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the active sequence early.
- half_period  in  CNT_W  cycles per high phase and per low phase; 0 is treated as 1.
- num_pulses  in  NUM_W  number of high/low pulse pairs; 0 is legal.
- busy  out  1  high from the cycle after `start` is accepted through the DONE cycle inclusive.
- done  out  1  single-cycle pulse at the end of every sequence (normal or aborted).
- d_out  out  1  registered drive to the `hello` `d` input.
- q_in  in  1  from the `hello` `q` output.
- pulse_cnt  out  NUM_W  number of completed pulse pairs in the current or last sequence.
- err  out  1  sticky mismatch flag (Optional Feature).

Behaviour:
- Reset values: `busy`=0, `done`=0, `d_out`=0, `pulse_cnt`=0, `err`=0, state=IDLE. Reset overrides every other input in the same cycle, including mid-sequence; `d_out` returns to 0 the next edge.
- States: IDLE, HIGH, LOW, DRAIN, DONE.
- IDLE:
  - `start`=1 at edge T latches `half_period` (0 becomes 1) and `num_pulses`, and clears `pulse_cnt`.
  - If `num_pulses`=0: go to DRAIN, `d_out` stays 0.
  - Otherwise: go to HIGH, with `d_out`=1 visible from T+1.
- HIGH: `d_out`=1 for exactly `half_period` cycles, then LOW.
- LOW:
  - `d_out`=0 for exactly `half_period` cycles.
  - On leaving LOW, `pulse_cnt` increments.
  - If `pulse_cnt` now equals the latched count, go to DRAIN; else go to HIGH.
- DRAIN: `d_out`=0 for LAT cycles, then DONE.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE; `busy` falls with the return to IDLE.
- abort:
  - In HIGH or LOW: go to DRAIN next edge, `d_out`=0 from that edge; `pulse_cnt` is not incremented for the partial pulse.
  - In IDLE, DRAIN or DONE: ignored.
- `start` while `busy`=1 is ignored. `start` in the DONE cycle is ignored. `start` and `abort` together in IDLE: the start is accepted.
- Counter wrap: the phase counter counts down from `half_period`-1 to 0. The maximum `half_period` of 2^CNT_W-1 must work without overflow. `pulse_cnt` never exceeds the latched count.
- Sequence length with no abort: 2·HP·N + LAT + 1 cycles from the start edge to the `done` cycle inclusive, where HP is the effective half-period (0→1) and N = `num_pulses`.

Optional Feature:
- Macro: HELLO_SEQ_CHECK_EN.
- With the macro:
  - A LAT-deep delay line tracks `d_out`.
  - From the (LAT+1)th cycle after start acceptance through the last DRAIN cycle, `q_in` is compared to the delayed `d_out` each cycle.
  - Any mismatch sets `err`. `err` is sticky until the next accepted `start` or `rst`.
- Without the macro: `err` is tied to 0, no delay line or comparator is instantiated, and the port list is unchanged.

Decomposition:
- Package `hello_pkg`:
  - State enum `hello_seq_state_t` (IDLE, HIGH, LOW, DRAIN, DONE).
  - Default constants HELLO_CNT_W=16, HELLO_NUM_W=8, HELLO_LAT=1.
- Sub-module `hello_seq_dly`: parameterised LAT-deep shift register with synchronous reset, used only under HELLO_SEQ_CHECK_EN.
- All other logic lives in `hello_seq`.

Test Plan:
- Basic train: `half_period`=4, `num_pulses`=3, `q_in` wired through a real `hello` (LAT=1).
  - `d_out` pattern is 4×1, 4×0, repeated 3 times.
  - `done` occurs 26 cycles after the start edge; `pulse_cnt`=3; `err`=0.
- Zero pulses: `num_pulses`=0.
  - `d_out` stays 0; `busy` is high for 2 cycles; one `done` pulse; `pulse_cnt`=0.
- Zero half-period: `half_period`=0, `num_pulses`=2.
  - Behaves as `half_period`=1: `d_out` is 1,0,1,0; `done` 6 cycles after the start edge.
- Abort: `half_period`=10, `num_pulses`=5, `abort` asserted in the 3rd cycle of the 2nd HIGH phase.
  - `d_out`=0 from the next edge; `pulse_cnt`=1; `done` LAT+1 cycles later.
- Restart and reset: `start` pulsed while `busy` is ignored. `rst` asserted in LOW.
  - All outputs are 0 next edge, state is IDLE; a new `start` then runs a clean sequence.
- Checker (macro defined): `q_in` forced to 0 while `half_period`=2, `num_pulses`=1.
  - `err`=1 by the first HIGH sample, held through `done`, cleared by the next `start`.
